// File: rtl/bp_pkg.sv
// bp_pkg: shared widths, counter reset value and saturating-counter helper
// for the branch-predictor update path.
package bp_pkg;

  localparam int unsigned PC_W_DEFAULT = 10;
  localparam int unsigned CTR_W        = 2;

  typedef logic [CTR_W-1:0] ctr_t;

  localparam ctr_t CTR_RESET = 2'b01;
  localparam ctr_t CTR_MAX   = '1;

  // Taken moves the counter toward CTR_MAX, not-taken toward zero; both saturate.
  function automatic ctr_t sat_next(input ctr_t ctr, input logic taken);
    ctr_t res;
    if (taken) begin
      res = (ctr == CTR_MAX) ? ctr : ctr + ctr_t'(1);
    end else begin
      res = (ctr == '0) ? ctr : ctr - ctr_t'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_inflight_queue.sv
// bp_inflight_queue: circular FIFO of {PC, counter snapshot} for in-flight
// branches. Pointers wrap modulo DEPTH; occupancy distinguishes full/empty.
// Optional feature macro: BP_UPDATE_FORWARD_EN (patch snapshots of remaining
// same-PC entries, and a same-cycle push, with the resolved next value).
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   push/push_pc/_ctr  accepted push (already gated by full/flush)
//   pop                accepted resolve, head is removed
//   flush              discard all entries, pointers back to 0
//   fwd_pc/fwd_ctr     resolved PC and its next counter (macro only)
//   head_pc/head_ctr   oldest entry
//   occupancy          number of valid entries
module bp_inflight_queue
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PC_W  = PC_W_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         push,
  input  logic [PC_W-1:0]              push_pc,
  input  ctr_t                         push_ctr,
  input  logic                         pop,
  input  logic                         flush,
`ifdef BP_UPDATE_FORWARD_EN
  input  logic [PC_W-1:0]              fwd_pc,
  input  ctr_t                         fwd_ctr,
`endif
  output logic [PC_W-1:0]              head_pc,
  output ctr_t                         head_ctr,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = $clog2(DEPTH+1);

  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [PC_W-1:0] pc_mem  [DEPTH];
  ctr_t            ctr_mem [DEPTH];
  ctr_t            wr_ctr;

  assign head_pc  = pc_mem[rd_ptr];
  assign head_ctr = ctr_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

`ifdef BP_UPDATE_FORWARD_EN
  logic [AW-1:0]    ofs [DEPTH];
  logic [DEPTH-1:0] patch;

  // An entry is live when its distance from rd_ptr (mod DEPTH) is below
  // occupancy; the head itself may be patched harmlessly as it is popping.
  always_comb begin
    patch = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ofs[i]   = AW'(i) - rd_ptr;
      patch[i] = pop && (OW'(ofs[i]) < occupancy) && (pc_mem[i] == fwd_pc);
    end
    wr_ctr = (pop && (push_pc == fwd_pc)) ? fwd_ctr : push_ctr;
  end
`else
  logic [DEPTH-1:0] patch;

  always_comb begin
    patch  = '0;
    wr_ctr = push_ctr;
  end
`endif

  // The push slot is never live (push is rejected when full), so the patch
  // loop and the push write never target the same entry.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
`ifdef BP_UPDATE_FORWARD_EN
      if (patch[i]) ctr_mem[i] <= fwd_ctr;
`else
      if (patch[i]) ctr_mem[i] <= ctr_mem[i];
`endif
    end
    if (push) begin
      pc_mem[wr_ptr]  <= push_pc;
      ctr_mem[wr_ptr] <= wr_ctr;
    end
  end

endmodule

// File: rtl/bp_update_unit.sv
// bp_update_unit: tracks predicted branches and, on in-order resolve, drives
// the predictor update port with the saturated next counter and a mispredict
// flag (one-cycle registered latency).
// Optional feature macro: BP_UPDATE_FORWARD_EN (same-PC snapshot forwarding).
// Ports:
//   clk, rstn                              clock, synchronous active-low reset
//   PushValid/PushReady/PushPC/PushCounter fetch-side predicted branch
//   ResolveValid/ResolveReady/ResolveTaken commit-side resolution of the head
//   Flush                                  discard all in-flight entries
//   CommitedBranchPC/CounterUpdate/NextValue predictor update port
//   Mispredict                             predicted direction was wrong
//   Occupancy                              valid entry count
module bp_update_unit
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PC_W  = PC_W_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         PushValid,
  output logic                         PushReady,
  input  logic [PC_W-1:0]              PushPC,
  input  logic [1:0]                   PushCounter,
  input  logic                         ResolveValid,
  output logic                         ResolveReady,
  input  logic                         ResolveTaken,
  input  logic                         Flush,
  output logic [PC_W-1:0]              CommitedBranchPC,
  output logic                         CounterUpdate,
  output logic [1:0]                   NextValue,
  output logic                         Mispredict,
  output logic [$clog2(DEPTH+1)-1:0]   Occupancy
);

  localparam int unsigned OW = $clog2(DEPTH+1);

  logic            push_acc;
  logic            pop_acc;
  logic [PC_W-1:0] head_pc;
  ctr_t            head_ctr;
  ctr_t            sat_val;

  // Readiness depends on registered occupancy only; a same-cycle pop does
  // not free a slot for a push.
  assign PushReady    = (Occupancy != OW'(DEPTH));
  assign ResolveReady = (Occupancy != '0);
  assign push_acc     = PushValid && PushReady && !Flush;
  assign pop_acc      = ResolveValid && ResolveReady;
  assign sat_val      = sat_next(head_ctr, ResolveTaken);

  bp_inflight_queue #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) u_queue (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push_acc),
    .push_pc   (PushPC),
    .push_ctr  (PushCounter),
    .pop       (pop_acc),
    .flush     (Flush),
`ifdef BP_UPDATE_FORWARD_EN
    .fwd_pc    (head_pc),
    .fwd_ctr   (sat_val),
`endif
    .head_pc   (head_pc),
    .head_ctr  (head_ctr),
    .occupancy (Occupancy)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      CommitedBranchPC <= '0;
      NextValue        <= CTR_RESET;
      CounterUpdate    <= 1'b0;
      Mispredict       <= 1'b0;
    end else begin
      CounterUpdate <= pop_acc;
      Mispredict    <= pop_acc && (head_ctr[1] != ResolveTaken);
      if (pop_acc) begin
        CommitedBranchPC <= head_pc;
        NextValue        <= sat_val;
      end
    end
  end

endmodule
